cache_fa_param: RTL and testbench
=================================

Name: cache_fa_param

Overview:
Parametrised fully-associative instruction cache. It succeeds the fixed 8-line, 1-word, random-replacement cache with configurable line count, multi-word blocks and a selectable replacement policy (FIFO or deterministic LFSR). A miss FSM runs a req/ack block fill from main memory. It sits between the PC/IF stage and main memory; HitWrite gates PCWrite/IFIDWrite.

Parameters:
LINES, 8, number of cache lines; power of 2, 2..64
WORDS, 1, 32-bit words per block; power of 2, 1..8
POLICY, 0, replacement when no invalid line exists: 0 = FIFO, 1 = LFSR pseudo-random
LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  synchronous, active-high reset
PC  in  32  fetch byte address; bits [1:0] ignored
Req  in  1  fetch request valid
HitWrite  out  1  1 = Data_Cache valid this cycle, pipeline may advance
Data_Cache  out  32  fetched instruction word
MM_Req  out  1  block-fill word request to main memory
MM_Addr  out  32  word address of current fill beat
MM_Ack  in  1  Data_MM valid for the current beat
Data_MM  in  32  main-memory read data
CNT_HIT  out  20  lookup-hit counter, saturating
CNT_MISS  out  20  miss counter, saturating

Behaviour:
- OFF = log2(WORDS), IDX = log2(LINES). Tag = PC[31:OFF+2]. Word select = PC[OFF+1:2]. Line = valid bit + tag + WORDS data words.
- Reset (sync): all valid bits 0, FIFO pointer 0, LFSR = LFSR_SEED, state IDLE. HitWrite 0, Data_Cache 0, MM_Req 0, MM_Addr 0, CNT_HIT 0, CNT_MISS 0. Reset during FILL aborts the fill; MM_Req is 0 from the next cycle and no line is written.
- Lookup (IDLE, combinational): hit = Req & some valid line with matching tag. Tags are unique, so multiple matches are impossible by construction.
- IDLE + hit: HitWrite = 1 and Data_Cache = selected word, both in the same cycle (0-cycle latency). CNT_HIT increments at the clock edge.
- IDLE + Req + miss: latch PC, pick the victim, CNT_MISS++, go to FILL. HitWrite = 0.
- IDLE + !Req: HitWrite 0, no state change. Data_Cache holds its last value.
- FILL: MM_Req = 1 and MM_Addr = {latched block base, beat counter, 2'b00}. Beats run 0..WORDS-1 in order. Each cycle with MM_Ack = 1, Data_MM is stored into the fill buffer at the beat index and the beat counter increments. After the last ack: write tag, data and valid = 1 into the victim line, then go to RESP. MM_Ack while not in FILL is ignored.
- RESP (1 cycle): HitWrite = 1, Data_Cache = the latched requested word from the fill buffer. CNT_HIT is not incremented. Then return to IDLE.
- PC and Req changes during FILL or RESP are ignored; the fill uses the latched address. HitWrite = 0 throughout FILL.
- Victim: lowest-index invalid line if any exists, else the policy line.
  - FIFO: pointer value; pointer increments mod LINES only when a valid line is replaced.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every cycle when not in reset; victim = lfsr[IDX-1:0] sampled at miss detection.
- Counters saturate at 20'hFFFFF (no wrap).
- Max miss latency = 1 + WORDS×(ack wait) + 1 cycles.

Test Plan:
- Reset, then Req with PC = 0x100, WORDS = 1, MM_Ack one cycle after MM_Req with Data_MM = 0xDEADBEEF. Required: MM_Addr = 0x100, RESP shows HitWrite = 1 with 0xDEADBEEF, CNT_MISS = 1. Re-fetching 0x100 gives a same-cycle hit and CNT_HIT = 1.
- WORDS = 4, miss at PC = 0x208. Required: MM_Addr sequences 0x200/0x204/0x208/0x20C across 4 acks (with 2-cycle ack gaps) and RESP returns beat 2. Then PCs 0x200, 0x204 and 0x20C all hit; CNT_MISS = 1, CNT_HIT = 3.
- POLICY = 0, LINES = 8, WORDS = 1, fill 9 distinct blocks A0..A8. Required: A8 evicts A0 (line 0), so refetching A0 misses and A1 hits; a 10th new block evicts line 1.
- POLICY = 1, LINES = 8, fill 9 blocks. Required: the 9th victim equals the model LFSR[2:0] at miss detection from seed 0xACE1, and the sequence is identical across two runs.
- Assert RESET mid-FILL after 1 of 4 acks. Required: MM_Req = 0 the next cycle, all lines invalid, counters 0, and the same PC misses again.
- Preload CNT_HIT near saturation (or force) and issue hits. Required: the counter holds at 0xFFFFF. Also hold Req = 0 with MM_Ack toggling: no state change and HitWrite stays 0.

Source files
------------

// File: rtl/cache_fa_param_if.sv
// Fetch-side and main-memory-side signals of the fully-associative instruction cache.
// The cache is the slave; the pipeline/memory environment is the master.
interface cache_fa_param_if;
  logic [31:0] PC;
  logic        Req;
  logic        HitWrite;
  logic [31:0] Data_Cache;
  logic        MM_Req;
  logic [31:0] MM_Addr;
  logic        MM_Ack;
  logic [31:0] Data_MM;
  logic [19:0] CNT_HIT;
  logic [19:0] CNT_MISS;

  modport master (
    output PC, Req, MM_Ack, Data_MM,
    input  HitWrite, Data_Cache, MM_Req, MM_Addr, CNT_HIT, CNT_MISS
  );

  modport slave (
    input  PC, Req, MM_Ack, Data_MM,
    output HitWrite, Data_Cache, MM_Req, MM_Addr, CNT_HIT, CNT_MISS
  );
endinterface

// File: rtl/cache_fa_param.sv
// Parametrised fully-associative instruction cache with multi-word blocks,
// FIFO or LFSR replacement and a req/ack block-fill state machine.
module cache_fa_param #(
  parameter int          LINES     = 8,
  parameter int          WORDS     = 1,
  parameter int          POLICY    = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic            CLK,
  input  logic            RESET,
  cache_fa_param_if.slave bus
);

  localparam int OFF   = $clog2(WORDS);
  localparam int IDX   = $clog2(LINES);
  localparam int TAG_W = 30 - OFF;
  localparam int AW    = IDX + OFF;

  typedef enum logic [1:0] {IDLE, FILL, RESP} state_t;

  state_t             state_q;
  logic [LINES-1:0]   valid_q;
  logic [TAG_W-1:0]   tag_mem  [LINES];
  logic [31:0]        data_mem [LINES*WORDS];
  logic [31:0]        fbuf     [8];
  logic [TAG_W-1:0]   req_tag_q;
  logic [3:0]         req_wsel_q;
  logic [3:0]         beat_q;
  logic [IDX-1:0]     victim_q;
  logic [IDX-1:0]     fifo_q;
  logic [15:0]        lfsr_q;
  logic [31:0]        data_q;
  logic [19:0]        cnt_hit_q;
  logic [19:0]        cnt_miss_q;

  logic [TAG_W-1:0]   pc_tag;
  logic [3:0]         pc_wsel;
  logic               hit_any;
  logic [IDX-1:0]     hit_line;
  logic               inv_any;
  logic [IDX-1:0]     inv_line;
  logic [IDX-1:0]     victim;
  logic               lookup_hit;
  logic               miss_start;
  logic               last_beat;
  logic               fill_done;
  logic [31:0]        hit_word;
  logic [31:0]        resp_word;
  logic               unused_pc;

  function automatic logic [19:0] sat_inc(input logic [19:0] c);
    return (c == 20'hFFFFF) ? c : c + 20'd1;
  endfunction

  // Fibonacci LFSR, taps 16,14,13,11
  function automatic logic [15:0] lfsr_next(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [AW-1:0] widx(input logic [IDX-1:0] line, input logic [3:0] w);
    return AW'(line) * AW'(WORDS) + AW'(w);
  endfunction

  assign pc_tag    = bus.PC[31:OFF+2];
  assign pc_wsel   = bus.PC[5:2] & 4'(WORDS - 1);
  assign unused_pc = ^bus.PC[1:0];

  // Tag search; the descending loop leaves the lowest invalid line selected.
  always_comb begin
    hit_any  = 1'b0;
    hit_line = '0;
    inv_any  = 1'b0;
    inv_line = '0;
    for (int i = LINES - 1; i >= 0; i--) begin
      if (valid_q[IDX'(i)] && (tag_mem[IDX'(i)] == pc_tag)) begin
        hit_any  = 1'b1;
        hit_line = IDX'(i);
      end
      if (!valid_q[IDX'(i)]) begin
        inv_any  = 1'b1;
        inv_line = IDX'(i);
      end
    end
  end

  assign victim     = inv_any ? inv_line : ((POLICY == 1) ? lfsr_q[IDX-1:0] : fifo_q);
  assign lookup_hit = (state_q == IDLE) && bus.Req && hit_any;
  assign miss_start = (state_q == IDLE) && bus.Req && !hit_any;
  assign last_beat  = (beat_q == 4'(WORDS - 1));
  assign fill_done  = (state_q == FILL) && bus.MM_Ack && last_beat;
  assign hit_word   = data_mem[widx(hit_line, pc_wsel)];
  // The final beat is not yet in the fill buffer when the line is committed.
  assign resp_word  = (req_wsel_q == beat_q) ? bus.Data_MM : fbuf[req_wsel_q[2:0]];

  assign bus.HitWrite   = lookup_hit || (state_q == RESP);
  assign bus.Data_Cache = lookup_hit ? hit_word : data_q;
  assign bus.MM_Req     = (state_q == FILL);
  assign bus.MM_Addr    = (state_q == FILL) ?
                          ({req_tag_q, {(OFF+2){1'b0}}} | {26'd0, beat_q, 2'b00}) : 32'd0;
  assign bus.CNT_HIT    = cnt_hit_q;
  assign bus.CNT_MISS   = cnt_miss_q;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      valid_q    <= '0;
      fifo_q     <= '0;
      lfsr_q     <= LFSR_SEED;
      beat_q     <= '0;
      data_q     <= '0;
      cnt_hit_q  <= '0;
      cnt_miss_q <= '0;
    end else begin
      lfsr_q <= lfsr_next(lfsr_q);
      case (state_q)
        IDLE: begin
          if (lookup_hit) begin
            cnt_hit_q <= sat_inc(cnt_hit_q);
            data_q    <= hit_word;
          end else if (miss_start) begin
            cnt_miss_q <= sat_inc(cnt_miss_q);
            beat_q     <= '0;
            if (!inv_any && (POLICY == 0)) fifo_q <= fifo_q + 1'b1;
            state_q    <= FILL;
          end
        end
        FILL: begin
          if (bus.MM_Ack) begin
            beat_q <= beat_q + 4'd1;
            if (last_beat) begin
              valid_q[victim_q] <= 1'b1;
              data_q            <= resp_word;
              state_q           <= RESP;
            end
          end
        end
        RESP:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  // Line storage and miss context; visibility is governed by valid_q alone.
  always_ff @(posedge CLK) begin
    if (miss_start) begin
      req_tag_q  <= pc_tag;
      req_wsel_q <= pc_wsel;
      victim_q   <= victim;
    end
    if ((state_q == FILL) && bus.MM_Ack) fbuf[beat_q[2:0]] <= bus.Data_MM;
    if (fill_done) begin
      tag_mem[victim_q] <= req_tag_q;
      for (int w = 0; w < WORDS; w++) begin
        data_mem[widx(victim_q, 4'(w))] <= (4'(w) == beat_q) ? bus.Data_MM : fbuf[3'(w)];
      end
    end
  end

endmodule

// File: tb/tb_cache_fa_param.sv
// Directed bench for cache_fa_param: three configurations share one stimulus
// path, selected by sel, with expected values worked out by hand or by a small LFSR model.
module tb_cache_fa_param;

  logic        CLK;
  logic        RESET;
  int          sel;
  logic [31:0] pc, dmm;
  logic        req, ack;
  logic        hw, mreq;
  logic [31:0] dc, maddr;
  logic [19:0] chit, cmiss;
  logic [15:0] m;
  int          ncmp, nerr;

  cache_fa_param_if if0 ();
  cache_fa_param_if if1 ();
  cache_fa_param_if if2 ();

  cache_fa_param #(.LINES(8), .WORDS(1), .POLICY(0)) u0 (.CLK(CLK), .RESET(RESET), .bus(if0));
  cache_fa_param #(.LINES(8), .WORDS(4), .POLICY(0)) u1 (.CLK(CLK), .RESET(RESET), .bus(if1));
  cache_fa_param #(.LINES(8), .WORDS(1), .POLICY(1)) u2 (.CLK(CLK), .RESET(RESET), .bus(if2));

  assign if0.PC = pc;  assign if0.Req = req && (sel == 0);  assign if0.MM_Ack = ack && (sel == 0);  assign if0.Data_MM = dmm;
  assign if1.PC = pc;  assign if1.Req = req && (sel == 1);  assign if1.MM_Ack = ack && (sel == 1);  assign if1.Data_MM = dmm;
  assign if2.PC = pc;  assign if2.Req = req && (sel == 2);  assign if2.MM_Ack = ack && (sel == 2);  assign if2.Data_MM = dmm;

  always_comb begin
    case (sel)
      1: begin hw = if1.HitWrite; dc = if1.Data_Cache; mreq = if1.MM_Req; maddr = if1.MM_Addr; chit = if1.CNT_HIT; cmiss = if1.CNT_MISS; end
      2: begin hw = if2.HitWrite; dc = if2.Data_Cache; mreq = if2.MM_Req; maddr = if2.MM_Addr; chit = if2.CNT_HIT; cmiss = if2.CNT_MISS; end
      default: begin hw = if0.HitWrite; dc = if0.Data_Cache; mreq = if0.MM_Req; maddr = if0.MM_Addr; chit = if0.CNT_HIT; cmiss = if0.CNT_MISS; end
    endcase
  end

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference LFSR: seed 0xACE1, taps 16,14,13,11, advancing every non-reset cycle
  always @(posedge CLK) begin
    if (RESET) m <= 16'hACE1;
    else       m <= {m[14:0], m[15] ^ m[13] ^ m[12] ^ m[10]};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Miss on address a, serve `words` beats with `gap` idle cycles before each ack.
  task automatic do_miss(input string tag, input logic [31:0] a, input int words,
                         input int gap, input logic [31:0] d0);
    logic [31:0] base, wsel;
    base = a & ~(32'(words * 4) - 32'd1);
    wsel = (a - base) >> 2;
    pc = a; req = 1'b1;
    #1 chk({tag, "_miss_hw"}, 32'(hw), 32'd0);
    @(negedge CLK);
    req = 1'b0;
    for (int b = 0; b < words; b++) begin
      repeat (gap) begin
        #1 chk({tag, "_wait_addr"}, maddr, base + 32'(4 * b));
        @(negedge CLK);
      end
      ack = 1'b1; dmm = d0 + 32'(b);
      #1 chk({tag, "_beat_addr"}, maddr, base + 32'(4 * b));
      chk({tag, "_beat_req"}, 32'(mreq), 32'd1);
      @(negedge CLK);
      ack = 1'b0;
    end
    #1 chk({tag, "_resp_hw"}, 32'(hw), 32'd1);
    chk({tag, "_resp_data"}, dc, d0 + wsel);
    chk({tag, "_resp_req"}, 32'(mreq), 32'd0);
    @(negedge CLK);
  endtask

  task automatic do_hit(input string tag, input logic [31:0] a, input logic [31:0] exp);
    pc = a; req = 1'b1;
    #1 chk({tag, "_hw"}, 32'(hw), 32'd1);
    chk({tag, "_data"}, dc, exp);
    @(negedge CLK);
    req = 1'b0;
  endtask

  initial begin
    logic [2:0] v;
    ncmp = 0; nerr = 0;
    sel = 0; pc = '0; req = 1'b0; ack = 1'b0; dmm = '0;
    RESET = 1'b1;
    repeat (3) @(negedge CLK);
    RESET = 1'b0;
    #1 chk("rst_hw", 32'(hw), 32'd0);
    chk("rst_data", dc, 32'd0);
    chk("rst_mmreq", 32'(mreq), 32'd0);
    chk("rst_mmaddr", maddr, 32'd0);
    chk("rst_cnthit", 32'(chit), 32'd0);
    chk("rst_cntmiss", 32'(cmiss), 32'd0);
    @(negedge CLK);

    // single-word fill, ack one cycle after MM_Req
    do_miss("t1", 32'h100, 1, 1, 32'hDEADBEEF);
    #1 chk("t1_cntmiss", 32'(cmiss), 32'd1);
    @(negedge CLK);
    do_hit("t1_hit", 32'h100, 32'hDEADBEEF);
    #1 chk("t1_cnthit", 32'(chit), 32'd1);
    chk("t1_idle_hw", 32'(hw), 32'd0);
    chk("t1_hold_data", dc, 32'hDEADBEEF);
    @(negedge CLK);

    // four-word block, 2-cycle ack gaps, miss on word 2
    sel = 1;
    do_reset();
    do_miss("t2", 32'h208, 4, 2, 32'h11110000);
    do_hit("t2_h0", 32'h200, 32'h11110000);
    do_hit("t2_h1", 32'h204, 32'h11110001);
    do_hit("t2_h3", 32'h20C, 32'h11110003);
    #1 chk("t2_cntmiss", 32'(cmiss), 32'd1);
    chk("t2_cnthit", 32'(chit), 32'd3);
    @(negedge CLK);

    // reset after 1 of 4 acks aborts the fill and clears everything
    pc = 32'h300; req = 1'b1;
    #1 chk("t5_miss_hw", 32'(hw), 32'd0);
    @(negedge CLK);
    req = 1'b0; ack = 1'b1; dmm = 32'h55555555;
    #1 chk("t5_req", 32'(mreq), 32'd1);
    @(negedge CLK);
    ack = 1'b0;
    #1 chk("t5_beat1_addr", maddr, 32'h304);
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    #1 chk("t5_mmreq_off", 32'(mreq), 32'd0);
    chk("t5_cnthit", 32'(chit), 32'd0);
    chk("t5_cntmiss", 32'(cmiss), 32'd0);
    chk("t5_hw", 32'(hw), 32'd0);
    @(negedge CLK);
    do_miss("t5_old", 32'h200, 4, 0, 32'h22220000);
    do_miss("t5_again", 32'h30C, 4, 0, 32'h33330000);
    #1 chk("t5_cntmiss2", 32'(cmiss), 32'd2);
    @(negedge CLK);

    // FIFO replacement over 9 blocks
    sel = 0;
    do_reset();
    for (int i = 0; i < 9; i++)
      do_miss($sformatf("t3_a%0d", i), 32'h1000 + 32'(4 * i), 1, 0, 32'hA0000000 + 32'(i));
    do_hit("t3_a1_hit", 32'h1004, 32'hA0000001);
    do_miss("t3_a0_re", 32'h1000, 1, 0, 32'hB0000000);
    do_hit("t3_a2_hit", 32'h1008, 32'hA0000002);
    do_miss("t3_a1_evicted", 32'h1004, 1, 0, 32'hB0000001);
    do_hit("t3_a8_hit", 32'h1020, 32'hA0000008);
    #1 chk("t3_cntmiss", 32'(cmiss), 32'd11);
    @(negedge CLK);

    // hit counter saturation
    force u0.cnt_hit_q = 20'hFFFFE;
    #1 release u0.cnt_hit_q;
    #1 chk("t6_preload", 32'(chit), 32'h000FFFFE);
    @(negedge CLK);
    for (int k = 0; k < 3; k++) begin
      do_hit($sformatf("t6_hit%0d", k), 32'h1020, 32'hA0000008);
      #1 chk($sformatf("t6_sat%0d", k), 32'(chit), 32'h000FFFFF);
      @(negedge CLK);
    end

    // Req low with MM_Ack toggling: nothing moves
    req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ack = (k % 2 == 0);
      #1 chk($sformatf("t6_idle_hw%0d", k), 32'(hw), 32'd0);
      chk($sformatf("t6_idle_req%0d", k), 32'(mreq), 32'd0);
      @(negedge CLK);
    end
    ack = 1'b0;
    #1 chk("t6_idle_cntmiss", 32'(cmiss), 32'd11);
    chk("t6_idle_cnthit", 32'(chit), 32'h000FFFFF);
    @(negedge CLK);

    // LFSR replacement, run twice from reset
    sel = 2;
    for (int r = 0; r < 2; r++) begin
      do_reset();
      for (int i = 0; i < 8; i++)
        do_miss($sformatf("t4r%0d_a%0d", r, i), 32'h2000 + 32'(4 * i), 1, 0, 32'hC0000000 + 32'(i));
      v = m[2:0];
      do_miss($sformatf("t4r%0d_a8", r), 32'h2020, 1, 0, 32'hC0000008);
      for (int i = 0; i < 8; i++)
        if (3'(i) != v)
          do_hit($sformatf("t4r%0d_keep%0d", r, i), 32'h2000 + 32'(4 * i), 32'hC0000000 + 32'(i));
      do_hit($sformatf("t4r%0d_a8_hit", r), 32'h2020, 32'hC0000008);
      do_miss($sformatf("t4r%0d_victim", r), 32'h2000 + 32'(4 * int'(v)), 1, 0, 32'hD0000000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
